// File: rtl/popcount_scheduler_if.sv
// ----------------------------------------------------------------------------
// popcount_scheduler_if
//
// Purpose: bundles the request and response channels of popcount_scheduler.
//
// Signals:
//   req_valid  [NUM_REQ]             per-requester request valid
//   req_ready  [NUM_REQ]             per-requester accept, at most one bit high
//   req_data   [NUM_REQ*DATA_WIDTH]  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid                       result available
//   resp_ready                       consumer accepts result
//   resp_count [DATA_WIDTH_LOG2+1]   number of set bits, 0..DATA_WIDTH
//   resp_id    [REQ_ID_WIDTH]        requester that produced the result
//   busy                             scheduler is not idle
//
// Optional feature macro: POPCOUNT_SCHEDULER_THRESHOLD_EN
//   adds threshold (input to the scheduler) and resp_above (output).
//
// Modports: master = requesters/consumer side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface popcount_scheduler_if #(
    parameter int NUM_REQ         = 2,
    parameter int REQ_ID_WIDTH    = 1,
    parameter int DATA_WIDTH      = 1024,
    parameter int DATA_WIDTH_LOG2 = 10
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [DATA_WIDTH_LOG2:0]      resp_count;
    logic [REQ_ID_WIDTH-1:0]       resp_id;
    logic                          busy;

`ifdef POPCOUNT_SCHEDULER_THRESHOLD_EN
    logic [DATA_WIDTH_LOG2:0]      threshold;
    logic                          resp_above;

    modport master (
        output req_valid, req_data, resp_ready, threshold,
        input  req_ready, resp_valid, resp_count, resp_id, busy, resp_above
    );

    modport slave (
        input  req_valid, req_data, resp_ready, threshold,
        output req_ready, resp_valid, resp_count, resp_id, busy, resp_above
    );
`else
    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_count, resp_id, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_count, resp_id, busy
    );
`endif
endinterface

// File: rtl/popcount_scheduler.sv
// ----------------------------------------------------------------------------
// popcount_scheduler
//
// Purpose: shares one chunk-wide popcount datapath between NUM_REQ requesters.
// A round-robin arbiter grants one request, its DATA_WIDTH vector is captured
// into a shadow register, counted CHUNK_WIDTH bits per cycle, and the total is
// returned with the requester ID over a valid/ready response channel.
//
// Ports:
//   clk  posedge clock
//   rst  synchronous active-high reset
//   bus  popcount_scheduler_if.slave (request/response channels, busy)
//
// Optional feature macro: POPCOUNT_SCHEDULER_THRESHOLD_EN
//   when defined, resp_above = (final count >= threshold), registered together
//   with resp_count; threshold is sampled in the last SCAN cycle.
// ----------------------------------------------------------------------------
module popcount_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int REQ_ID_WIDTH    = 1,
    parameter int DATA_WIDTH      = 1024,
    parameter int DATA_WIDTH_LOG2 = 10,
    parameter int CHUNK_WIDTH     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    popcount_scheduler_if.slave  bus
);
    localparam int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CHUNK_IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CNT_W       = DATA_WIDTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                                 state, state_next;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_data_arr;
    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] shadow;
    logic [CHUNK_IDX_W-1:0]                 chunk_idx;
    logic [CNT_W-1:0]                       acc, chunk_count, sum, resp_count;
    logic [REQ_ID_WIDTH-1:0]                last_grant, grant_idx, cand, cur_id, resp_id;
    logic [NUM_REQ-1:0]                     req_ready;
    logic                                   grant_found, accept, last_chunk;

    assign req_data_arr = bus.req_data;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise a latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = REQ_ID_WIDTH'((int'(last_grant) + off) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state logic and req_ready (only the granted bit, only in IDLE).
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = SCAN;
                end
            end
            SCAN: if (last_chunk)     state_next = RESP;
            RESP: if (bus.resp_ready) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // The grant is only offered to a valid requester, so a grant in IDLE is
    // the handshake.
    assign accept      = (state == IDLE) && grant_found;
    assign last_chunk  = (chunk_idx == CHUNK_IDX_W'(NUM_CHUNKS - 1));
    assign chunk_count = CNT_W'($countones(shadow[chunk_idx]));
    assign sum         = acc + chunk_count;

    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the shadow register has no reset; it is always loaded on accept
    // before any chunk of it is counted, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (accept) shadow <= req_data_arr[grant_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            chunk_idx  <= '0;
            last_grant <= REQ_ID_WIDTH'(NUM_REQ - 1);
            cur_id     <= '0;
            resp_count <= '0;
            resp_id    <= '0;
        end else if (accept) begin
            acc        <= '0;
            chunk_idx  <= '0;
            last_grant <= grant_idx;
            cur_id     <= grant_idx;
        end else if (state == SCAN) begin
            acc       <= sum;
            chunk_idx <= chunk_idx + 1'b1;
            if (last_chunk) begin
                resp_count <= sum;
                resp_id    <= cur_id;
            end
        end
    end

`ifdef POPCOUNT_SCHEDULER_THRESHOLD_EN
    logic resp_above;

    always_ff @(posedge clk) begin
        if (rst)
            resp_above <= 1'b0;
        else if ((state == SCAN) && last_chunk)
            resp_above <= (sum >= bus.threshold);
    end

    assign bus.resp_above = resp_above;
`else
    // Threshold compare absent in this build.
`endif

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_count = resp_count;
    assign bus.resp_id    = resp_id;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_popcount_scheduler.sv
// ----------------------------------------------------------------------------
// tb_popcount_scheduler
//
// Purpose: directed self-checking bench for popcount_scheduler with the default
// geometry (2 requesters, 1024-bit vectors, 64-bit chunks => 16 chunks).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// away from the edge.
// Optional feature macro: POPCOUNT_SCHEDULER_THRESHOLD_EN enables the
// threshold/resp_above checks.
// ----------------------------------------------------------------------------
module tb_popcount_scheduler;
    localparam int NUM_REQ         = 2;
    localparam int REQ_ID_WIDTH    = 1;
    localparam int DATA_WIDTH      = 1024;
    localparam int DATA_WIDTH_LOG2 = 10;
    localparam int CHUNK_WIDTH     = 64;
    localparam int DW              = DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    popcount_scheduler_if #(
        .NUM_REQ(NUM_REQ), .REQ_ID_WIDTH(REQ_ID_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .DATA_WIDTH_LOG2(DATA_WIDTH_LOG2)
    ) bus ();

    popcount_scheduler #(
        .NUM_REQ(NUM_REQ), .REQ_ID_WIDTH(REQ_ID_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .DATA_WIDTH_LOG2(DATA_WIDTH_LOG2),
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle after accept (T+1); returns cycles since T.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        check("resp_valid_seen", bus.resp_valid, 1);
    endtask

    // One complete request/response with an immediate consumer.
    task automatic run_req(input string tag, input logic [1:0] valid,
                           input logic [1:0] exp_ready, input int exp_count,
                           input int exp_id);
        int lat;
        bus.req_valid = valid;
        #1;
        check({tag, "_ready"}, bus.req_ready, exp_ready);
        step();
        bus.req_valid = '0;
        check({tag, "_busy"}, bus.busy, 1);
        wait_resp(lat);
        check({tag, "_latency"}, lat, 17);
        check({tag, "_count"}, bus.resp_count, exp_count);
        check({tag, "_id"}, bus.resp_id, exp_id);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check({tag, "_idle_after"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int prev_cyc;
        logic saw_resp;

        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
`ifdef POPCOUNT_SCHEDULER_THRESHOLD_EN
        bus.threshold  = '0;
`endif

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_count", bus.resp_count, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_busy", bus.busy, 0);
`ifdef POPCOUNT_SCHEDULER_THRESHOLD_EN
        check("rst_resp_above", bus.resp_above, 0);
`endif

        // All-ones on requester 0: full 1024 count, response at T+17
        bus.req_data[DW-1:0] = '1;
        run_req("all_ones", 2'b01, 2'b01, 1024, 0);

        // Alternation: both valid, ids 0,1,0,1, counts 4,1,4,1, 18-cycle spacing
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_data          = '0;
        bus.req_data[3:0]     = 4'hF;
        bus.req_data[2*DW-1]  = 1'b1;
        bus.resp_ready        = 1'b1;
        bus.req_valid         = 2'b11;
        prev_cyc              = 0;
        for (int k = 0; k < 4; k++) begin
            wait_resp(lat);
            check("alt_id", bus.resp_id, k % 2);
            check("alt_count", bus.resp_count, (k % 2 == 0) ? 4 : 1);
            if (k > 0) check("alt_spacing", cyc - prev_cyc, 18);
            prev_cyc = cyc;
            if (k == 3) bus.req_valid = '0;
            step();
        end
        bus.resp_ready = 1'b0;
        check("alt_idle", bus.busy, 0);

        // Backpressure: 0xAAAA... on requester 1, consumer stalls 10 cycles
        bus.req_data          = '0;
        bus.req_data[2*DW-1:DW] = {512{2'b10}};
        bus.req_valid         = 2'b10;
        #1;
        check("bp_ready", bus.req_ready, 2'b10);
        step();
        bus.req_valid = '0;
        wait_resp(lat);
        check("bp_latency", lat, 17);
        check("bp_count", bus.resp_count, 512);
        check("bp_id", bus.resp_id, 1);
        bus.req_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_hold_valid", bus.resp_valid, 1);
            check("bp_hold_count", bus.resp_count, 512);
            check("bp_hold_id", bus.resp_id, 1);
            check("bp_hold_req_ready", bus.req_ready, 0);
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check("bp_idle_after", bus.busy, 0);
        check("bp_valid_after", bus.resp_valid, 0);
        check("bp_count_kept", bus.resp_count, 512);
        check("bp_id_kept", bus.resp_id, 1);

        // Reset during SCAN at chunk 7 discards the request
        bus.req_data    = '0;
        bus.req_data[0] = 1'b1;
        bus.req_valid   = 2'b01;
        #1;
        check("mid_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = '0;
        repeat (7) step();
        check("mid_busy_before", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_req_ready", bus.req_ready, 0);
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_resp_count", bus.resp_count, 0);
        check("mid_rst_resp_id", bus.resp_id, 0);
        check("mid_rst_busy", bus.busy, 0);
        saw_resp = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (20) begin
            step();
            if (bus.resp_valid === 1'b1) saw_resp = 1'b1;
        end
        bus.resp_ready = 1'b0;
        check("mid_no_stale_resp", saw_resp, 0);

        // Requester 1 alone with all-zeros data
        bus.req_data = '0;
        run_req("zeros_req1", 2'b10, 2'b10, 0, 1);

        // Both valid after requester 1 won: requester 0 next, only bit 0 set
        bus.req_data[0] = 1'b1;
        run_req("bit0_req0", 2'b11, 2'b01, 1, 0);

`ifdef POPCOUNT_SCHEDULER_THRESHOLD_EN
        // Threshold compare at the boundary and at zero
        bus.req_data            = '0;
        bus.req_data[2*DW-1:DW] = {512{2'b10}};
        bus.threshold           = 11'd512;
        run_req("thr_512", 2'b10, 2'b10, 512, 1);
        check("thr_512_above", bus.resp_above, 1);
        bus.threshold = 11'd513;
        run_req("thr_513", 2'b10, 2'b10, 512, 1);
        check("thr_513_above", bus.resp_above, 0);
        bus.req_data  = '0;
        bus.threshold = 11'd0;
        run_req("thr_0", 2'b10, 2'b10, 0, 1);
        check("thr_0_above", bus.resp_above, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/popcount_scheduler.md
Name: popcount_scheduler

Overview:
- Shares a single chunk-wide popcount datapath between NUM_REQ requesters in the continuous monitoring system.
- Grants requests round-robin and captures the granted requester's DATA_WIDTH vector.
- Walks the vector in CHUNK_WIDTH slices, one slice per cycle, accumulating the count of set bits.
- Returns the total with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 2: number of requesters (>=2).
- REQ_ID_WIDTH, 1: width of the requester ID; 2**REQ_ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 1024: bits per request vector.
- DATA_WIDTH_LOG2, 10: log2(DATA_WIDTH), given explicitly.
- CHUNK_WIDTH, 64: bits counted per cycle. DATA_WIDTH % CHUNK_WIDTH == 0. NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_count  out  DATA_WIDTH_LOG2+1  number of set bits, range 0..DATA_WIDTH.
- resp_id  out  REQ_ID_WIDTH  index of the requester that produced the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, SCAN, RESP.
- Reset (rst=1 at posedge):
  - state=IDLE; req_ready=0; resp_valid=0; resp_count=0; resp_id=0; busy=0.
  - accumulator=0; chunk index=0; round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-SCAN or mid-RESP discards the in-flight request; no response is produced for it.
- IDLE:
  - req_ready is combinational from state, req_valid and last_grant.
  - The grant goes to the first requester with req_valid=1, searching last_grant+1, last_grant+2, ... with wrap at NUM_REQ.
  - Only the granted bit of req_ready is high. req_ready is 0 in SCAN and RESP.
  - On handshake (req_valid[g] & req_ready[g]):
    - capture req_data slice g into the shadow register; capture g as the ID.
    - last_grant=g; accumulator=0; chunk index=0; go to SCAN.
  - Requesters must hold valid and data stable until accepted; the block never depends on data after the accept cycle.
- SCAN:
  - Each cycle: accumulator += popcount(shadow[k*CHUNK_WIDTH +: CHUNK_WIDTH]); k += 1.
  - After chunk NUM_CHUNKS-1 is added, register the final sum into resp_count and the ID into resp_id, and go to RESP.
- RESP:
  - resp_valid=1; resp_count and resp_id are held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready: resp_valid=0 next cycle, go to IDLE.
  - resp_count and resp_id keep their last values after the handshake.
- Latency:
  - Accept at cycle T; SCAN occupies T+1..T+NUM_CHUNKS; resp_valid first high at T+NUM_CHUNKS+1.
  - Minimum request-to-request spacing is NUM_CHUNKS+2 cycles: one idle bubble after the response handshake.
- Width rules:
  - Accumulator and resp_count are DATA_WIDTH_LOG2+1 bits, so all-ones gives exactly DATA_WIDTH with no overflow.
  - Per-chunk popcount is zero-extended before the add.
- Boundaries:
  - A requester dropping req_valid before grant is legal; it is simply not granted.
  - Requests arriving while busy wait; no queueing beyond the single shadow register.
  - Simultaneous requests are resolved only by the round-robin order.

Optional Feature:
- Macro: POPCOUNT_SCHEDULER_THRESHOLD_EN.
- Defined:
  - adds input threshold (DATA_WIDTH_LOG2+1 bits) and output resp_above (1 bit).
  - resp_above is registered with resp_count: (final count >= threshold), with threshold sampled in the last SCAN cycle.
  - resp_above resets to 0.
- Undefined: neither port exists; no compare logic.

Test Plan:
- req0 valid, data all-ones, DATA_WIDTH=1024, CHUNK_WIDTH=64 -> req_ready[0] high at T; resp_valid at T+17; resp_count=1024; resp_id=0.
- req0 and req1 valid continuously, data0=0x0F (4 ones), data1=bit 1023 only, resp_ready=1 -> responses alternate id 0,1,0,1 with counts 4,1,4,1; spacing 18 cycles.
- Single request, resp_ready held 0 for 10 cycles after resp_valid -> resp_valid, resp_count, resp_id stable; req_ready=0 throughout; IDLE entered the cycle after resp_ready=1.
- rst=1 for one cycle at SCAN chunk 7 -> next cycle all outputs 0, busy=0. Then req1 alone with all-zeros data -> resp_count=0, id=1. Then both requesters valid -> req0 granted first.
- Pattern 0xAAAA... (512 ones) on req1 -> resp_count=512. Pattern with only bit 0 set -> resp_count=1.
- THRESHOLD_EN, pattern 0xAAAA...: threshold=512 -> resp_above=1; threshold=513 -> resp_above=0; threshold=0 with all-zeros data -> resp_above=1.
